// File: rtl/mini_src_control_unit.sv
// rtl/mini_src_control_unit.sv - Mini SRC multi-cycle hardwired control unit
// Ports: clk, clr (sync active-high reset), IR (opcode in [31:27]), CON_FF,
// Stop (halt request at instruction end); outputs are the datapath strobes,
// Clear (asserted in reset) and Run (high in fetch/execute).
module mini_src_control_unit (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        Stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCout,
  output logic        MDRout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        HIout,
  output logic        LOout,
  output logic        InPortout,
  output logic        Cout,
  output logic        PCin,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        MARin,
  output logic        MDRin,
  output logic        HIin,
  output logic        LOin,
  output logic        CONin,
  output logic        OUTPort_in,
  output logic        IncPC,
  output logic        Read,
  output logic        Write,
  output logic        Clear,
  output logic        Run
);

  typedef enum logic [1:0] {PH_RST, PH_FETCH, PH_EXEC, PH_HALT} phase_t;

  localparam logic [4:0] OP_LD   = 5'd0,  OP_LDI  = 5'd1,  OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3,  OP_OR   = 5'd10, OP_ADDI = 5'd11;
  localparam logic [4:0] OP_ORI  = 5'd13, OP_MUL  = 5'd14, OP_DIV  = 5'd15;
  localparam logic [4:0] OP_NEG  = 5'd16, OP_NOT  = 5'd17, OP_BR   = 5'd18;
  localparam logic [4:0] OP_JR   = 5'd19, OP_JAL  = 5'd20, OP_IN   = 5'd21;
  localparam logic [4:0] OP_OUT  = 5'd22, OP_MFHI = 5'd23, OP_MFLO = 5'd24;
  localparam logic [4:0] OP_HALT = 5'd26;

  phase_t     phase, phase_nxt;
  logic [2:0] step, step_nxt;
  logic [4:0] opcode;
  logic [2:0] last_step;

  assign opcode = IR[31:27];

  // Index of the final execute step for each opcode.
  always_comb begin
    last_step = 3'd0;
    if (opcode == OP_LD)                            last_step = 3'd5;
    else if (opcode == OP_ST)                       last_step = 3'd4;
    else if (opcode >= OP_LDI && opcode <= OP_ORI)  last_step = 3'd2;
    else if (opcode == OP_MUL || opcode == OP_DIV)  last_step = 3'd3;
    else if (opcode == OP_NEG || opcode == OP_NOT)  last_step = 3'd1;
    else if (opcode == OP_BR)                       last_step = 3'd3;
    else if (opcode == OP_JAL)                      last_step = 3'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      phase <= PH_RST;
      step  <= 3'd0;
    end else begin
      phase <= phase_nxt;
      step  <= step_nxt;
    end
  end

  always_comb begin
    {Gra, Grb, Grc, Rin, Rout, BAout} = '0;
    {PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout} = '0;
    {PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OUTPort_in} = '0;
    {IncPC, Read, Write, Clear, Run} = '0;
    // Anything not explicitly routed (including undefined steps) lands on F0.
    phase_nxt = PH_FETCH;
    step_nxt  = 3'd0;

    case (phase)
      PH_RST: Clear = 1'b1;

      PH_FETCH: begin
        Run = 1'b1;
        case (step)
          3'd0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; step_nxt = 3'd1; end
          3'd1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; step_nxt = 3'd2; end
          3'd2: begin Read = 1'b1; MDRin = 1'b1; step_nxt = 3'd3; end
          3'd3: begin MDRout = 1'b1; IRin = 1'b1; phase_nxt = PH_EXEC; end
          default: Run = 1'b1;
        endcase
      end

      PH_EXEC: begin
        Run = 1'b1;
        if (step <= last_step) begin
          if (opcode == OP_LD || opcode == OP_ST || opcode == OP_LDI) begin
            case (step)
              3'd0: begin Grb = 1'b1; BAout = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              3'd1: begin Cout = 1'b1; Zin = 1'b1; end
              3'd2: begin
                Zlowout = 1'b1;
                if (opcode == OP_LDI) begin Gra = 1'b1; Rin = 1'b1; end
                else MARin = 1'b1;
              end
              3'd3: begin
                if (opcode == OP_LD) Read = 1'b1;
                else begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
              end
              3'd4: begin
                if (opcode == OP_LD) begin Read = 1'b1; MDRin = 1'b1; end
                else Write = 1'b1;
              end
              default: begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            endcase
          end else if (opcode >= OP_ADD && opcode <= OP_ORI) begin
            case (step)
              3'd0: begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
              3'd1: begin
                Zin = 1'b1;
                // Register-register forms take the second operand from rc,
                // immediate forms from the sign-extended constant.
                if (opcode <= OP_OR) begin Grc = 1'b1; Rout = 1'b1; end
                else Cout = 1'b1;
              end
              default: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
            endcase
          end else begin
            case (opcode)
              OP_MUL, OP_DIV: begin
                case (step)
                  3'd0:    begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
                  3'd1:    begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                  3'd2:    begin Zlowout = 1'b1; LOin = 1'b1; end
                  default: begin Zhighout = 1'b1; HIin = 1'b1; end
                endcase
              end
              OP_NEG, OP_NOT: begin
                if (step == 3'd0) begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
                else begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              end
              OP_BR: begin
                case (step)
                  3'd0:    begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                  3'd1:    begin PCout = 1'b1; Yin = 1'b1; end
                  3'd2:    begin Cout = 1'b1; Zin = 1'b1; end
                  default: begin Zlowout = 1'b1; PCin = CON_FF; end
                endcase
              end
              OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              OP_JAL: begin
                if (step == 3'd0) begin PCout = 1'b1; Grb = 1'b1; Rin = 1'b1; end
                else begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
              end
              OP_IN:   begin InPortout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OUTPort_in = 1'b1; end
              OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
              default: Run = 1'b1;
            endcase
          end

          if (step == last_step) begin
            // Stop is only looked at here, so earlier pulses are dropped.
            if (Stop || opcode == OP_HALT) phase_nxt = PH_HALT;
          end else begin
            phase_nxt = PH_EXEC;
            step_nxt  = step + 3'd1;
          end
        end
      end

      PH_HALT: phase_nxt = PH_HALT;

      default: phase_nxt = PH_FETCH;
    endcase
  end

endmodule

// File: tb/tb_mini_src_control_unit.sv
// tb/tb_mini_src_control_unit.sv - randomized self-checking bench for mini_src_control_unit
module tb_mini_src_control_unit;

  typedef logic [28:0] ctl_t;

  localparam ctl_t GRA     = ctl_t'(1) << 0,  GRB     = ctl_t'(1) << 1,  GRC    = ctl_t'(1) << 2;
  localparam ctl_t RIN     = ctl_t'(1) << 3,  ROUT    = ctl_t'(1) << 4,  BAOUT  = ctl_t'(1) << 5;
  localparam ctl_t PCOUT   = ctl_t'(1) << 6,  MDROUT  = ctl_t'(1) << 7,  ZHOUT  = ctl_t'(1) << 8;
  localparam ctl_t ZLOUT   = ctl_t'(1) << 9,  HIOUT   = ctl_t'(1) << 10, LOOUT  = ctl_t'(1) << 11;
  localparam ctl_t INPOUT  = ctl_t'(1) << 12, COUT    = ctl_t'(1) << 13, PCIN   = ctl_t'(1) << 14;
  localparam ctl_t IRIN    = ctl_t'(1) << 15, YIN     = ctl_t'(1) << 16, ZIN    = ctl_t'(1) << 17;
  localparam ctl_t MARIN   = ctl_t'(1) << 18, MDRIN   = ctl_t'(1) << 19, HIIN   = ctl_t'(1) << 20;
  localparam ctl_t LOIN    = ctl_t'(1) << 21, CONIN   = ctl_t'(1) << 22, OUTPIN = ctl_t'(1) << 23;
  localparam ctl_t INCPC   = ctl_t'(1) << 24, READ    = ctl_t'(1) << 25, WRITE  = ctl_t'(1) << 26;
  localparam ctl_t CLEAR   = ctl_t'(1) << 27, RUN     = ctl_t'(1) << 28;

  logic        clk = 1'b0;
  logic        clr, CON_FF, Stop;
  logic [31:0] IR;
  logic Gra, Grb, Grc, Rin, Rout, BAout, PCout, MDRout, Zhighout, Zlowout, HIout, LOout;
  logic InPortout, Cout, PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OUTPort_in;
  logic IncPC, Read, Write, Clear, Run;
  ctl_t obs;

  int checks = 0;
  int failures = 0;
  ctl_t exp_q[$];

  always #5 clk = ~clk;

  mini_src_control_unit dut (
    .clk(clk), .clr(clr), .IR(IR), .CON_FF(CON_FF), .Stop(Stop),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .PCout(PCout), .MDRout(MDRout), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .HIout(HIout), .LOout(LOout), .InPortout(InPortout), .Cout(Cout),
    .PCin(PCin), .IRin(IRin), .Yin(Yin), .Zin(Zin), .MARin(MARin), .MDRin(MDRin),
    .HIin(HIin), .LOin(LOin), .CONin(CONin), .OUTPort_in(OUTPort_in),
    .IncPC(IncPC), .Read(Read), .Write(Write), .Clear(Clear), .Run(Run)
  );

  assign obs = {Run, Clear, Write, Read, IncPC, OUTPort_in, CONin, LOin, HIin, MDRin, MARin,
                Zin, Yin, IRin, PCin, Cout, InPortout, LOout, HIout, Zlowout, Zhighout,
                MDRout, PCout, BAout, Rout, Rin, Grc, Grb, Gra};

  // Reference: the full per-cycle strobe list of one instruction, fetch included.
  task automatic build_seq(input logic [4:0] op, input bit con);
    ctl_t wb;
    ctl_t addr[$];
    wb = ZLOUT | GRA | RIN;
    addr = '{GRB | BAOUT | ROUT | YIN, COUT | ZIN, ZLOUT | MARIN};
    exp_q = '{PCOUT | MARIN | INCPC | ZIN, ZLOUT | PCIN | READ, READ | MDRIN, MDROUT | IRIN};
    if (op == 5'd0)
      exp_q = {exp_q, addr, READ, READ | MDRIN, MDROUT | GRA | RIN};
    else if (op == 5'd2)
      exp_q = {exp_q, addr, GRA | ROUT | MDRIN, WRITE};
    else if (op == 5'd1)
      exp_q = {exp_q, GRB | BAOUT | ROUT | YIN, COUT | ZIN, wb};
    else if (op >= 5'd3 && op <= 5'd10)
      exp_q = {exp_q, GRB | ROUT | YIN, GRC | ROUT | ZIN, wb};
    else if (op >= 5'd11 && op <= 5'd13)
      exp_q = {exp_q, GRB | ROUT | YIN, COUT | ZIN, wb};
    else if (op == 5'd14 || op == 5'd15)
      exp_q = {exp_q, GRA | ROUT | YIN, GRB | ROUT | ZIN, ZLOUT | LOIN, ZHOUT | HIIN};
    else if (op == 5'd16 || op == 5'd17)
      exp_q = {exp_q, GRB | ROUT | ZIN, wb};
    else if (op == 5'd18)
      exp_q = {exp_q, GRA | ROUT | CONIN, PCOUT | YIN, COUT | ZIN, ZLOUT | (con ? PCIN : ctl_t'(0))};
    else if (op == 5'd19) exp_q.push_back(GRA | ROUT | PCIN);
    else if (op == 5'd20) exp_q = {exp_q, PCOUT | GRB | RIN, GRA | ROUT | PCIN};
    else if (op == 5'd21) exp_q.push_back(INPOUT | GRA | RIN);
    else if (op == 5'd22) exp_q.push_back(GRA | ROUT | OUTPIN);
    else if (op == 5'd23) exp_q.push_back(HIOUT | GRA | RIN);
    else if (op == 5'd24) exp_q.push_back(LOOUT | GRA | RIN);
    else exp_q.push_back(ctl_t'(0));
    for (int i = 0; i < exp_q.size(); i++) exp_q[i] = exp_q[i] | RUN;
  endtask

  // Entered just after the edge that starts F0; leaves just after the edge
  // that ends the last execute step.
  task automatic run_instr(input logic [4:0] op, input bit con, input bit stop_e0,
                           input bit stop_last, input bit noise, input string tag);
    int n;
    build_seq(op, con);
    n = exp_q.size();
    IR = {op, 27'($urandom)};
    CON_FF = con;
    for (int i = 0; i < n; i++) begin
      if (i == n - 1) Stop = stop_last;
      else Stop = (stop_e0 && i == 4) || (noise && ($urandom_range(0, 1) == 1));
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL %s op=%0d cycle=%0d got=%h exp=%h", tag, op, i, obs, exp_q[i]);
      end
      @(posedge clk); #1;
    end
    Stop = 1'b0;
  endtask

  task automatic do_reset();
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    clr = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== CLEAR) begin failures++; $display("FAIL reset_init got=%h exp=%h", obs, CLEAR); end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== CLEAR) begin failures++; $display("FAIL reset_release got=%h exp=%h", obs, CLEAR); end
    @(posedge clk); #1;
    // Run a ld up to E3, then hit it with a two-cycle clr.
    build_seq(5'd0, 1'b0);
    IR = {5'd0, 27'($urandom)};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== exp_q[i]) begin
        failures++;
        $display("FAIL reset_ld_prefix cycle=%0d got=%h exp=%h", i, obs, exp_q[i]);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
    clr = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== CLEAR) begin failures++; $display("FAIL reset_mid_ld k=%0d got=%h exp=%h", k, obs, CLEAR); end
    end
    clr = 1'b0;
    @(negedge clk);
    checks++;
    if (obs !== CLEAR) begin failures++; $display("FAIL reset_mid_release got=%h exp=%h", obs, CLEAR); end
    @(posedge clk); #1;
    run_instr(5'd25, 1'b0, 1'b0, 1'b0, 1'b0, "reset_then_nop");
  endtask

  task automatic test_add();
    run_instr(5'd3, 1'b0, 1'b0, 1'b0, 1'b0, "add");
    IR = 32'h18910000;
    run_instr(IR[31:27], 1'b0, 1'b0, 1'b0, 1'b0, "add_ir");
  endtask

  task automatic test_ld_st();
    run_instr(5'd0, 1'b0, 1'b0, 1'b0, 1'b0, "ld");
    run_instr(5'd2, 1'b0, 1'b0, 1'b0, 1'b0, "st");
  endtask

  task automatic test_br();
    run_instr(5'd18, 1'b0, 1'b0, 1'b0, 1'b0, "br_con0");
    run_instr(5'd18, 1'b1, 1'b0, 1'b0, 1'b0, "br_con1");
  endtask

  task automatic test_mul_div();
    run_instr(5'd14, 1'b0, 1'b0, 1'b0, 1'b0, "mul");
    run_instr(5'd15, 1'b0, 1'b0, 1'b0, 1'b0, "div");
  endtask

  task automatic test_stop_e0();
    run_instr(5'd3, 1'b0, 1'b1, 1'b0, 1'b0, "stop_e0_add");
    run_instr(5'd23, 1'b0, 1'b0, 1'b0, 1'b0, "after_stop_e0");
  endtask

  task automatic test_random();
    logic [4:0] op;
    for (int n = 0; n < 40; n++) begin
      op = 5'($urandom_range(0, 31));
      if (op == 5'd26) op = 5'd25;
      run_instr(op, 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1, "random");
    end
  endtask

  task automatic check_halted(input int cycles, input string tag);
    for (int c = 0; c < cycles; c++) begin
      Stop = 1'($urandom_range(0, 1));
      CON_FF = 1'($urandom_range(0, 1));
      IR = $urandom;
      @(negedge clk);
      checks++;
      if (obs !== ctl_t'(0)) begin
        failures++;
        $display("FAIL %s cycle=%0d got=%h exp=%h", tag, c, obs, ctl_t'(0));
      end
      @(posedge clk); #1;
    end
    Stop = 1'b0;
  endtask

  task automatic test_stop_end();
    run_instr(5'd3, 1'b0, 1'b0, 1'b1, 1'b0, "stop_end_add");
    check_halted(6, "stop_end_halted");
    do_reset();
    run_instr(5'd1, 1'b0, 1'b0, 1'b0, 1'b0, "after_halt_reset");
  endtask

  task automatic test_halt();
    run_instr(5'd26, 1'b0, 1'b0, 1'b0, 1'b0, "halt_op");
    check_halted(20, "halt_op_idle");
    do_reset();
    run_instr(5'd20, 1'b0, 1'b0, 1'b0, 1'b0, "jal_after_halt");
  endtask

  initial begin
    clr = 1'b1;
    IR = 32'h0;
    CON_FF = 1'b0;
    Stop = 1'b0;
    test_reset();
    test_add();
    test_ld_st();
    test_br();
    test_mul_div();
    test_stop_e0();
    test_random();
    test_stop_end();
    test_halt();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mini_src_control_unit.md
# mini_src_control_unit

Multi-cycle hardwired control unit for the Mini SRC datapath. It drives every datapath strobe through fetch and execute, using the instruction register's opcode (IR[31:27]), the branch condition flop (CON_FF), and an external Stop request. It sits beside the datapath at top level: its outputs connect 1:1 to the datapath control inputs, and IR plus CON_FF are fed back to it.

## Interface
- No parameters. Opcode encoding is fixed: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, jal 10100, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010.
- clk  in  1  sole clock, rising edge.
- clr  in  1  reset: synchronous, active-high. One clock; reset is synchronous and active-high.
- IR  in  32  instruction register contents; only [31:27] are decoded.
- CON_FF  in  1  branch condition result.
- Stop  in  1  level request to halt after the current instruction.
- Gra, Grb, Grc, Rin, Rout, BAout  out  1 each  register select/encode strobes.
- PCout, MDRout, Zhighout, Zlowout, HIout, LOout, InPortout, Cout  out  1 each  bus drivers.
- PCin, IRin, Yin, Zin, MARin, MDRin, HIin, LOin, CONin, OUTPort_in  out  1 each  register loads.
- IncPC, Read, Write  out  1 each  ALU increment; memory read select; memory write enable.
- Clear  out  1  datapath register clear.
- Run  out  1  high while executing.

## Operation
- State is a register {phase: RST, FETCH, EXEC, HALT} plus a 3-bit step counter. Outputs are a pure combinational decode of state, step, and opcode (Moore with respect to the state register). Any strobe not listed for a step is 0.
- RST: Clear=1, Run=0. Next state is FETCH step 0.
- FETCH: Run=1 in all non-RST, non-HALT states.
  - F0: PCout, MARin, IncPC, Zin.
  - F1: Zlowout, PCin, Read.
  - F2: Read, MDRin. This is the RAM wait cycle; Read is held.
  - F3: MDRout, IRin. Next state is EXEC step 0.
- EXEC steps E0..E5, by opcode:
  - add/sub/shr/shl/ror/rol/and/or: E0 Grb,Rout,Yin; E1 Grc,Rout,Zin; E2 Zlowout,Gra,Rin.
  - addi/andi/ori: E0 Grb,Rout,Yin; E1 Cout,Zin; E2 Zlowout,Gra,Rin.
  - ldi: E0 Grb,BAout,Rout,Yin; E1 Cout,Zin; E2 Zlowout,Gra,Rin.
  - ld: E0 Grb,BAout,Rout,Yin; E1 Cout,Zin; E2 Zlowout,MARin; E3 Read; E4 Read,MDRin; E5 MDRout,Gra,Rin.
  - st: E0–E2 as ld; E3 Gra,Rout,MDRin (Read=0); E4 Write.
  - mul/div: E0 Gra,Rout,Yin; E1 Grb,Rout,Zin; E2 Zlowout,LOin; E3 Zhighout,HIin.
  - neg/not: E0 Grb,Rout,Zin; E1 Zlowout,Gra,Rin.
  - br: E0 Gra,Rout,CONin; E1 PCout,Yin; E2 Cout,Zin; E3 Zlowout, with PCin = CON_FF (sampled combinationally in E3).
  - jr: E0 Gra,Rout,PCin.
  - jal: E0 PCout,Grb,Rin (link register is selected by the rb field); E1 Gra,Rout,PCin.
  - in: E0 InPortout,Gra,Rin. out: E0 Gra,Rout,OUTPort_in. mfhi: E0 HIout,Gra,Rin. mflo: E0 LOout,Gra,Rin.
  - nop and unused opcodes (11011–11111): E0 with no strobes.
  - halt: E0 with no strobes, then HALT.
- Instruction end: after the last EXEC step, go to HALT if Stop=1 is sampled on that edge, otherwise go to FETCH F0.
- HALT: Run=0, all strobes 0. Exits only through clr.

## Timing
- Every state lasts exactly one clk. Total cycles per instruction = 4 fetch + N exec.
  - R-type/imm/ldi: 7. ld: 10. st: 9. mul/div: 8. br: 8. neg/not: 6. jal: 6. jr/in/out/mfhi/mflo/nop: 5.
- clr has priority over everything, including mid-instruction. On the clocking edge, state becomes RST.
  - During RST: Clear=1; Run and all strobes are 0.
  - The first F0 is the cycle after clr deasserts.
- Stop is sampled only at instruction end. Stop pulses that fall before the last EXEC step are ignored (no latching).
- Read is never asserted together with Write. MDRin is asserted with Read only in F2 and in ld E4.
- Undefined states (phase/step combinations not listed) return to F0 with all strobes 0.

## Test plan
- Reset: hold clr 2 cycles mid-ld E3. Require Clear=1, Run=0, Write=0 throughout. Then F0 follows with PCout=MARin=IncPC=Zin=1 and Run=1.
- add (IR=0x18910000, opcode 00011): require fetch strobes F0–F3 exactly as specified, then E0 Grb/Rout/Yin, E1 Grc/Rout/Zin, E2 Zlowout/Gra/Rin. Next F0 arrives 7 cycles after the first F0.
- ld then st: require ld Read high in E3–E4, MDRin only in E4, 10 cycles total. For st, require Write high only in E4, Read=0 in E3, 9 cycles total.
- br with CON_FF=0, then CON_FF=1: require PCin=0 vs PCin=1 in E3, and the CONin pulse in E0 only.
- mul: require LOin in E2 and HIin in E3, never simultaneously.
- halt and Stop:
  - halt opcode: Run drops to 0 after E0, and strobes stay 0 for 20 cycles.
  - Stop=1 during an add's E2: HALT is entered instead of F0.
  - Stop pulse only in E0: no halt.
